// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, buffers words in a small prefetch
// FIFO and hands them to decode over a valid/ready handshake; handles start, redirect and halt.
module fetch_ctrl #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INST_W  = 16,
  parameter int unsigned DEPTH   = 2,
  parameter logic [3:0]  HALT_OP = 4'hF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              halted,
  output logic              busy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] fpc, fpc_next;
  logic [INST_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic [PTR_W-1:0]  wptr, rptr;
  logic [CNT_W-1:0]  count;
  logic              flush, push, pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      fpc   <= '0;
    end else begin
      state <= state_next;
      fpc   <= fpc_next;
    end
  end

  // A start seen while already fetching is a redirect to start_pc; redirect_pc wins ties.
  always_comb begin
    state_next = state;
    fpc_next   = fpc;
    push       = 1'b0;
    flush      = redirect || (start && state == FETCH);
    pop        = inst_valid && inst_ready && !flush;
    if (redirect) begin
      state_next = FETCH;
      fpc_next   = redirect_pc;
    end else if (start) begin
      state_next = FETCH;
      fpc_next   = start_pc;
    end else if (state == FETCH && (count < CNT_W'(DEPTH) || pop)) begin
      push     = 1'b1;
      fpc_next = fpc + 1'b1;
      if (imem_data[INST_W-1 -: 4] == HALT_OP) state_next = HALTED;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        data_q[wptr] <= imem_data;
        pc_q[wptr]   <= fpc;
        wptr         <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign imem_addr  = fpc;
  assign inst_valid = (count != '0);
  assign inst_out   = data_q[rptr];
  assign inst_pc    = pc_q[rptr];
  assign halted     = (state == HALTED);
  assign busy       = (state == FETCH);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed scenarios push expected {pc,inst} pairs,
// a negedge monitor pops and compares every accepted handshake.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  start_pc = '0;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_pc = '0;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [15:0] inst_out;
  logic [7:0]  inst_pc;
  logic        halted;
  logic        busy;

  logic [15:0] mem [256];
  logic [23:0] exp_q [$];
  int          vec = 0, err = 0;
  int          mon_vec = 0, mon_err = 0;

  always #5 clk = ~clk;
  assign imem_data = mem[imem_addr];

  fetch_ctrl #(.ADDR_W(8), .INST_W(16), .DEPTH(2), .HALT_OP(4'hF)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .imem_addr(imem_addr),
    .imem_data(imem_data), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_out(inst_out), .inst_pc(inst_pc), .halted(halted), .busy(busy)
  );

  // Monitor: a word is consumed when the handshake is up and no flush or reset blocks it.
  always @(negedge clk) begin
    logic [23:0] e;
    if (rst_n && inst_valid && inst_ready && !redirect && !(start && busy)) begin
      mon_vec++;
      if (exp_q.size() == 0) begin
        mon_err++;
        $display("FAIL accept: unexpected pc=%h inst=%h, scoreboard empty", inst_pc, inst_out);
      end else begin
        e = exp_q.pop_front();
        if ({inst_pc, inst_out} !== e) begin
          mon_err++;
          $display("FAIL accept: got pc=%h inst=%h, want pc=%h inst=%h",
                   inst_pc, inst_out, e[23:16], e[15:0]);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    vec++;
    if (act !== want) begin
      err++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  task automatic base_mem();
    for (int i = 0; i < 256; i++) mem[i] = {8'h1A, 8'(i)};
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
  endtask

  task automatic wait_halt(input string name);
    int n;
    n = 0;
    while (!halted && n < 40) begin
      tick(1);
      n++;
    end
    check(name, {31'd0, halted}, 32'd1);
  endtask

  task automatic drained(input string name);
    tick(4);
    check(name, exp_q.size(), 32'd0);
  endtask

  initial begin
    base_mem();
    // reset state
    tick(2);
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_out",   {16'd0, inst_out},   32'd0);
    check("rst_pc",    {24'd0, inst_pc},    32'd0);
    check("rst_halted",{31'd0, halted},     32'd0);
    check("rst_busy",  {31'd0, busy},       32'd0);
    check("rst_addr",  {24'd0, imem_addr},  32'd0);
    rst_n = 1'b1;
    tick(3);
    check("idle_addr",  {24'd0, imem_addr}, 32'd0);
    check("idle_valid", {31'd0, inst_valid}, 32'd0);

    // start at 10, latency and consecutive delivery
    mem[8'h10] = 16'h1111; mem[8'h11] = 16'h2222; mem[8'h12] = 16'h3333; mem[8'h13] = 16'hF013;
    exp_q.push_back({8'h10, 16'h1111}); exp_q.push_back({8'h11, 16'h2222});
    exp_q.push_back({8'h12, 16'h3333}); exp_q.push_back({8'h13, 16'hF013});
    inst_ready = 1'b1; start_pc = 8'h10; start = 1'b1;
    tick(1);
    start = 1'b0;
    check("t1_valid0", {31'd0, inst_valid}, 32'd0);
    check("t1_busy",   {31'd0, busy},       32'd1);
    check("t1_addr",   {24'd0, imem_addr},  32'h10);
    tick(1);
    check("t1_valid1", {31'd0, inst_valid}, 32'd1);
    check("t1_pc10",   {24'd0, inst_pc},    32'h10);
    check("t1_out10",  {16'd0, inst_out},   32'h1111);
    tick(1);
    check("t1_pc11",   {24'd0, inst_pc},    32'h11);
    tick(1);
    check("t1_pc12",   {24'd0, inst_pc},    32'h12);
    wait_halt("t1_halt");
    drained("t1_drain");
    check("t1_addr_h", {24'd0, imem_addr},  32'h14);
    base_mem();
    do_reset();

    // backpressure, then halt at PC 3
    mem[8'h03] = 16'hF000;
    inst_ready = 1'b0; start_pc = 8'h00; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(5);
    check("bp_valid", {31'd0, inst_valid}, 32'd1);
    check("bp_addr",  {24'd0, imem_addr},  32'h02);
    check("bp_out",   {16'd0, inst_out},   32'h1A00);
    check("bp_pc",    {24'd0, inst_pc},    32'h00);
    exp_q.push_back({8'h00, 16'h1A00}); exp_q.push_back({8'h01, 16'h1A01});
    exp_q.push_back({8'h02, 16'h1A02}); exp_q.push_back({8'h03, 16'hF000});
    inst_ready = 1'b1;
    wait_halt("bp_halt");
    drained("bp_drain");
    do_reset();

    // halt with no backpressure, then redirect resumes
    exp_q.push_back({8'h00, 16'h1A00}); exp_q.push_back({8'h01, 16'h1A01});
    exp_q.push_back({8'h02, 16'h1A02}); exp_q.push_back({8'h03, 16'hF000});
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_halt("h_halt");
    drained("h_drain");
    check("h_addr",  {24'd0, imem_addr},  32'h04);
    check("h_valid", {31'd0, inst_valid}, 32'd0);
    check("h_busy",  {31'd0, busy},       32'd0);
    mem[8'h22] = 16'hF022;
    exp_q.push_back({8'h20, 16'h1A20}); exp_q.push_back({8'h21, 16'h1A21});
    exp_q.push_back({8'h22, 16'hF022});
    redirect_pc = 8'h20; redirect = 1'b1;
    tick(1);
    redirect = 1'b0;
    check("h_redir_addr", {24'd0, imem_addr}, 32'h20);
    check("h_redir_busy", {31'd0, busy},      32'd1);
    wait_halt("h_halt2");
    drained("h_drain2");
    base_mem();
    do_reset();

    // PC wrap
    mem[8'h01] = 16'hF001;
    exp_q.push_back({8'hFE, 16'h1AFE}); exp_q.push_back({8'hFF, 16'h1AFF});
    exp_q.push_back({8'h00, 16'h1A00}); exp_q.push_back({8'h01, 16'hF001});
    start_pc = 8'hFE; start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_halt("w_halt");
    drained("w_drain");
    base_mem();
    do_reset();

    // redirect mid-stream discards buffered PCs 5 and 6
    mem[8'h41] = 16'hF041;
    inst_ready = 1'b0; start_pc = 8'h05; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2);
    check("r_head", {24'd0, inst_pc},   32'h05);
    check("r_addr", {24'd0, imem_addr}, 32'h07);
    exp_q.push_back({8'h40, 16'h1A40}); exp_q.push_back({8'h41, 16'hF041});
    redirect_pc = 8'h40; redirect = 1'b1; inst_ready = 1'b1;
    tick(1);
    redirect = 1'b0;
    check("r_valid0", {31'd0, inst_valid}, 32'd0);
    tick(1);
    check("r_valid1", {31'd0, inst_valid}, 32'd1);
    check("r_pc40",   {24'd0, inst_pc},    32'h40);
    wait_halt("r_halt");
    drained("r_drain");
    base_mem();
    do_reset();

    // start and redirect together: redirect target wins
    mem[8'h60] = 16'hF060;
    exp_q.push_back({8'h60, 16'hF060});
    start_pc = 8'h50; redirect_pc = 8'h60; start = 1'b1; redirect = 1'b1;
    tick(1);
    start = 1'b0; redirect = 1'b0;
    check("sr_addr", {24'd0, imem_addr}, 32'h60);
    wait_halt("sr_halt");
    drained("sr_drain");
    base_mem();
    do_reset();

    // reset mid-operation with two entries buffered
    inst_ready = 1'b0; start_pc = 8'h30; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    check("m_full", {31'd0, inst_valid}, 32'd1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    inst_ready = 1'b1;
    check("m_valid",  {31'd0, inst_valid}, 32'd0);
    check("m_halted", {31'd0, halted},     32'd0);
    check("m_busy",   {31'd0, busy},       32'd0);
    check("m_addr",   {24'd0, imem_addr},  32'd0);
    tick(4);
    check("m_idle_addr",  {24'd0, imem_addr},  32'd0);
    check("m_idle_valid", {31'd0, inst_valid}, 32'd0);
    check("m_drain", exp_q.size(), 32'd0);

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vec + mon_vec, err + mon_err);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the 256x16 instruction memory for the S-Machine core.
- Owns the fetch PC and drives the memory address. Buffers fetched words in a small prefetch FIFO and hands them to the decoder with a valid/ready handshake.
- Handles start, branch redirect with flush, and halt-opcode detection.
- Sits between the instruction memory, which has an asynchronous read, and the decode stage.

Parameters:
- ADDR_W, 8, instruction address width. PC arithmetic wraps modulo 2^ADDR_W.
- INST_W, 16, instruction width.
- DEPTH, 2, prefetch FIFO entries. Must be a power of 2 and ≥ 2.
- HALT_OP, 4'hF, value of inst[INST_W-1:INST_W-4] that marks a halt instruction.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  pulse: begin fetching at start_pc.
- start_pc  in  ADDR_W  initial fetch address.
- redirect  in  1  branch taken: flush and refetch from redirect_pc.
- redirect_pc  in  ADDR_W  branch target.
- imem_addr  out  ADDR_W  address to the instruction memory; equals fpc, combinational from the register.
- imem_data  in  INST_W  memory word at imem_addr, same cycle.
- inst_valid  out  1  FIFO head is valid.
- inst_ready  in  1  decoder accepts the head.
- inst_out  out  INST_W  head instruction.
- inst_pc  out  ADDR_W  address of the head instruction.
- halted  out  1  high in HALTED state.
- busy  out  1  high in FETCH state.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, fpc=0, FIFO emptied (count=0, pointers 0).
  - inst_valid=0, inst_out=0, inst_pc=0, halted=0, busy=0, imem_addr=0.
  - Reset wins over every other input, including mid-fetch; any FIFO content is discarded.
- States:
  - IDLE: no fetch. start=1 → FETCH, fpc<=start_pc.
  - FETCH: fetch runs when push_ok = (count<DEPTH) || pop.
    - On push: write {fpc, imem_data} at the tail, fpc<=fpc+1 (wraps 255→0).
    - If the pushed word has top nibble == HALT_OP, go to HALTED after this push; fpc holds at halt address+1.
  - HALTED: no fetch. The FIFO keeps draining to the decoder. start or redirect → FETCH with the new PC.
- Handshake:
  - pop = inst_valid && inst_ready.
  - inst_valid = (count != 0), registered state only.
  - inst_out and inst_pc reflect the head combinationally from FIFO storage.
  - inst_out and inst_pc are stable while inst_valid=1 and inst_ready=0.
- Latency: a word is fetched at edge N and appears at the head after edge N, i.e. one cycle from address to inst_valid when the FIFO was empty.
- Simultaneous push and pop when full: allowed; count unchanged.
- Redirect:
  - Highest priority after reset, in any state.
  - Clears the FIFO (count=0), sets fpc<=redirect_pc, state<=FETCH.
  - No push and no pop that cycle, even if inst_ready=1. inst_valid is therefore 0 the next cycle; the first target word is valid two cycles after the redirect edge.
- start while in FETCH with redirect=0: treated as a redirect to start_pc (same flush rules).
- Both start and redirect in the same cycle: redirect_pc wins.
- count width: clog2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.

Test Plan:
- Reset then start, start_pc=8'h10, inst_ready=1, mem[10..12]=16'h1111/2222/3333:
  - inst_valid rises one cycle after start is sampled.
  - inst_pc sequence 10,11,12 on consecutive cycles, inst_out matching.
- Backpressure: inst_ready=0 for 5 cycles after start at 0:
  - FIFO fills to 2; imem_addr holds at 2; inst_out stays mem[0].
  - Raise inst_ready: PCs 0,1,2,3 delivered with no gap or duplicate.
- Wrap: start_pc=8'hFE:
  - inst_pc sequence FE, FF, 00, 01.
- Redirect mid-stream: FIFO holding PCs 5 and 6, redirect=1, redirect_pc=8'h40, inst_ready=1:
  - PCs 5 and 6 never accepted; inst_valid=0 the next cycle.
  - Then inst_pc=40 with mem[40].
- Halt: mem[3]=16'hF000, start at 0:
  - PCs 0..3 delivered, halted=1 after the push of PC 3, imem_addr stays 4, no further valid words.
  - redirect to 8'h20 resumes fetching at 20.
- Reset mid-operation: rst_n=0 for one cycle with 2 entries buffered:
  - Next cycle inst_valid=0, state IDLE, halted=0, busy=0, imem_addr=0.
  - Nothing fetched until start.
